// File: rtl/spartan_fifo_sync.sv
// Single-clock FIFO with valid/ready on both sides and a registered first-word-fall-through output.
// LEVEL counts the RAM contents plus the output register; full and empty are derived from LEVEL.
module spartan_fifo_sync #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDRW      = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  DIN_VAL,
    output logic                  DIN_RDY,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DOUT_VAL,
    input  logic                  DOUT_RDY,
    output logic [ADDRW:0]        LEVEL,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY
);

    localparam int             DEPTH    = 2**ADDRW;
    localparam logic [ADDRW:0] FULL_LVL = (ADDRW+1)'(DEPTH);
    localparam logic [ADDRW:0] AF_LVL   = (ADDRW+1)'(AF_THRESH);
    localparam logic [ADDRW:0] AE_LVL   = (ADDRW+1)'(AE_THRESH);
    localparam logic [ADDRW:0] ONE_LVL  = (ADDRW+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDRW-1:0]      wr_ptr;
    logic [ADDRW-1:0]      rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  out_load;
    logic                  ram_has_data;
    logic                  ram_rd;
    logic                  ram_wr;
    logic                  bypass;
    logic [ADDRW:0]        ram_level;
    logic [ADDRW:0]        level_nxt;

    always_comb begin
        push         = DIN_VAL && DIN_RDY;
        pop          = DOUT_VAL && DOUT_RDY;
        ram_level    = LEVEL - {{ADDRW{1'b0}}, DOUT_VAL};
        ram_has_data = (ram_level != '0);
        // The output register refills whenever it is empty or being drained this cycle.
        out_load     = !DOUT_VAL || pop;
        ram_rd       = out_load && ram_has_data;
        // With the RAM empty, incoming data goes straight to the output register.
        bypass       = out_load && !ram_has_data && push;
        ram_wr       = push && !bypass;

        level_nxt = LEVEL;
        if (FLUSH) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = LEVEL + ONE_LVL;
        end else if (!push && pop) begin
            level_nxt = LEVEL - ONE_LVL;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            DOUT         <= '0;
            DOUT_VAL     <= 1'b0;
            LEVEL        <= '0;
            DIN_RDY      <= 1'b1;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            LEVEL        <= level_nxt;
            DIN_RDY      <= (level_nxt != FULL_LVL);
            ALMOST_FULL  <= (level_nxt >= AF_LVL);
            ALMOST_EMPTY <= (level_nxt <= AE_LVL);
            if (FLUSH) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                DOUT_VAL <= 1'b0;
            end else begin
                if (ram_wr) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (ram_rd) begin
                    DOUT     <= mem[rd_ptr];
                    DOUT_VAL <= 1'b1;
                    rd_ptr   <= rd_ptr + 1'b1;
                end else if (bypass) begin
                    DOUT     <= DIN;
                    DOUT_VAL <= 1'b1;
                end else if (out_load) begin
                    DOUT_VAL <= 1'b0;
                end
            end
        end
    end

    // Storage has no reset so it maps onto distributed RAM.
    always_ff @(posedge CLK) begin
        if (ram_wr && !FLUSH) begin
            mem[wr_ptr] <= DIN;
        end
    end

endmodule
